icu_biu_fetch: RTL and testbench

//  ICU-side fetch bus engine, directly upstream of icu_nocache/icu_dpath. Accepts a fetch

---
 rtl/icu_biu_fetch_pkg.sv | 44 ++++
 rtl/icu_biu_fetch_if.sv | 39 +++
 rtl/icu_biu_beat_addr.sv | 32 +++
 rtl/icu_biu_fetch.sv | 139 +++++++++++++
 tb/tb_icu_biu_fetch.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/icu_biu_fetch_pkg.sv
// Shared definitions for the ICU fetch bus engine.
//   - address/data widths
//   - default timeout and line length
//   - ack codes, size codes and FSM state encodings
//   - ack_code(): maps the beat outcome to the code returned to the ICU
package icu_biu_fetch_pkg;

  localparam int ADDR_W       = 32;
  localparam int DATA_W       = 32;
  localparam int TMO_CYC_DEF  = 255;
  localparam int LINE_WDS_DEF = 4;
  localparam int CNT_W        = 8;

  typedef enum logic [1:0] {
    ACK_NONE = 2'b00,
    ACK_WORD = 2'b01,
    ACK_ERR  = 2'b10,
    ACK_LAST = 2'b11
  } ack_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_LINE = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_RSP  = 2'b10,
    ST_ERR  = 2'b11
  } state_e;

  // A cancelled transfer never reports anything, not even an error.
  function automatic ack_e ack_code(input logic i_cancel, input logic i_err,
                                    input logic i_last);
    if (i_cancel)    return ACK_NONE;
    else if (i_err)  return ACK_ERR;
    else if (i_last) return ACK_LAST;
    else             return ACK_WORD;
  endfunction

endpackage

// File: rtl/icu_biu_fetch_if.sv
// Bundle of the ICU-side request/return signals and the memory beat bus.
//   master : the fetch engine (drives mem_* requests and biu_* returns)
//   slave  : the environment (ICU + memory)
interface icu_biu_fetch_if;
  import icu_biu_fetch_pkg::*;

  logic              icu_req;
  logic [ADDR_W-1:0] icu_biu_addr;
  logic [3:0]        icu_type;
  logic [1:0]        icu_size;
  logic              icu_cancel;

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_type;
  logic [1:0]        mem_size;
  logic              mem_ack;
  logic              mem_err;
  logic [DATA_W-1:0] mem_rdata;

  logic [DATA_W-1:0] biu_data;
  logic [1:0]        biu_icu_ack;
  logic              biu_busy;

  modport master (
    input  icu_req, icu_biu_addr, icu_type, icu_size, icu_cancel,
    input  mem_ack, mem_err, mem_rdata,
    output mem_req, mem_addr, mem_type, mem_size,
    output biu_data, biu_icu_ack, biu_busy
  );

  modport slave (
    output icu_req, icu_biu_addr, icu_type, icu_size, icu_cancel,
    output mem_ack, mem_err, mem_rdata,
    input  mem_req, mem_addr, mem_type, mem_size,
    input  biu_data, biu_icu_ack, biu_busy
  );

endinterface

// File: rtl/icu_biu_beat_addr.sv
// Combinational wrap-address generator for fetch beats.
//   i_base  : captured fetch byte address
//   i_beat  : beat index within the transfer
//   i_line  : 1 = line fill (word aligned, wraps inside the line)
//   o_addr  : address to put on the memory bus for this beat
// Non-line transfers pass the base address through untouched.
module icu_biu_beat_addr
  import icu_biu_fetch_pkg::*;
#(
  parameter int LINE_WDS = LINE_WDS_DEF,
  parameter int BEAT_W   = $clog2(LINE_WDS)
) (
  input  logic [ADDR_W-1:0] i_base,
  input  logic [BEAT_W-1:0] i_beat,
  input  logic              i_line,
  output logic [ADDR_W-1:0] o_addr
);

  logic [BEAT_W-1:0] w_idx;

  // Word index inside the line; natural overflow of the narrow add is the wrap.
  assign w_idx = i_base[BEAT_W+1:2] + i_beat;

  always_comb begin
    o_addr = i_base;
    if (i_line) begin
      o_addr[BEAT_W+1:2] = w_idx;
      o_addr[1:0]        = 2'b00;
    end
  end

endmodule

// File: rtl/icu_biu_fetch.sv
// ICU fetch bus engine. Runs one fetch request as single-word memory beats
// (one beat for byte/half/word, LINE_WDS critical-word-first beats for a line)
// and returns each word with a registered one-cycle ack pulse.
//   clk, reset : clock, synchronous active-high reset
//   bus        : icu_biu_fetch_if.master
//                ICU in : icu_req, icu_biu_addr, icu_type, icu_size, icu_cancel
//                mem out: mem_req, mem_addr, mem_type, mem_size
//                mem in : mem_ack, mem_err, mem_rdata
//                ICU out: biu_data, biu_icu_ack, biu_busy
module icu_biu_fetch
  import icu_biu_fetch_pkg::*;
#(
  parameter int TMO_CYC  = TMO_CYC_DEF,
  parameter int LINE_WDS = LINE_WDS_DEF
) (
  input  logic            clk,
  input  logic            reset,
  icu_biu_fetch_if.master bus
);

  localparam int BEAT_W = $clog2(LINE_WDS);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_type;
  size_e             r_size;
  logic [BEAT_W-1:0] r_beat;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_cancel;
  ack_e              r_ack;
  ack_e              w_ack_nxt;
  logic [DATA_W-1:0] r_data;

  logic              w_line;
  logic              w_last;
  logic              w_tmo;
  logic              w_cancel;
  logic [ADDR_W-1:0] w_beat_addr;

  assign w_line   = (r_size == SZ_LINE);
  assign w_last   = !w_line || (r_beat == BEAT_W'(LINE_WDS - 1));
  assign w_tmo    = (r_cnt == CNT_W'(TMO_CYC));
  // A cancel arriving in the same cycle as the ack already suppresses it.
  assign w_cancel = r_cancel || bus.icu_cancel;

  icu_biu_beat_addr #(
    .LINE_WDS (LINE_WDS),
    .BEAT_W   (BEAT_W)
  ) u_beat_addr (
    .i_base (r_addr),
    .i_beat (r_beat),
    .i_line (w_line),
    .o_addr (w_beat_addr)
  );

  // Next state and the ack code to be registered for the following cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_ack_nxt   = ACK_NONE;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.icu_req) w_state_nxt = ST_REQ;
      end
      ST_REQ: begin
        // An ack in the expiry cycle wins over the timeout.
        if (bus.mem_ack) begin
          w_state_nxt = bus.mem_err ? ST_ERR : ST_RSP;
          w_ack_nxt   = ack_code(w_cancel, bus.mem_err, w_last);
        end else if (w_tmo) begin
          w_state_nxt = ST_ERR;
          w_ack_nxt   = ack_code(w_cancel, 1'b1, w_last);
        end
      end
      ST_RSP: begin
        w_state_nxt = w_last ? ST_IDLE : ST_REQ;
      end
      ST_ERR: begin
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_addr   <= '0;
      r_type   <= '0;
      r_size   <= SZ_BYTE;
      r_beat   <= '0;
      r_cnt    <= '0;
      r_cancel <= 1'b0;
      r_ack    <= ACK_NONE;
      r_data   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ack   <= w_ack_nxt;
      unique case (r_state)
        ST_IDLE: begin
          r_cancel <= 1'b0;
          if (bus.icu_req) begin
            r_addr <= bus.icu_biu_addr;
            r_type <= bus.icu_type;
            r_size <= size_e'(bus.icu_size);
            r_beat <= '0;
            r_cnt  <= '0;
          end
        end
        ST_REQ: begin
          if (bus.icu_cancel) r_cancel <= 1'b1;
          if (bus.mem_ack) begin
            r_cnt  <= '0;
            r_data <= bus.mem_rdata;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RSP: begin
          if (bus.icu_cancel) r_cancel <= 1'b1;
          if (!w_last) r_beat <= r_beat + 1'b1;
        end
        ST_ERR: begin
          if (bus.icu_cancel) r_cancel <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_req     = (r_state == ST_REQ);
  assign bus.mem_addr    = w_beat_addr;
  assign bus.mem_type    = r_type;
  assign bus.mem_size    = w_line ? SZ_WORD : r_size;
  assign bus.biu_data    = r_data;
  assign bus.biu_icu_ack = r_ack;
  assign bus.biu_busy    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_icu_biu_fetch.sv
// Randomized bench for icu_biu_fetch: the bench plays both ICU and memory,
// and a transaction-level model predicts beat addresses, acks and data.
module tb_icu_biu_fetch;
  import icu_biu_fetch_pkg::*;

  localparam int TMO      = 255;
  localparam int LINE_WDS = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_pass = 0;

  icu_biu_fetch_if bif ();

  icu_biu_fetch #(
    .TMO_CYC  (TMO),
    .LINE_WDS (LINE_WDS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!reset && bif.mem_ack)
      assert (bif.mem_req) else $error("mem_ack driven outside a beat request");

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Expected beat address: line fills walk the words of the aligned line
  // starting at the requested word; other sizes use the address as given.
  function automatic logic [31:0] exp_addr(input logic [31:0] a, input logic [1:0] sz,
                                           input int n);
    int unsigned idx;
    if (sz != 2'b11) return a;
    idx = ((a >> 2) + n) % LINE_WDS;
    return (a & ~32'(LINE_WDS * 4 - 1)) | 32'(idx * 4);
  endfunction

  // One complete fetch. Beat indices select where to cancel, error, time out,
  // or answer at the very last allowed cycle (-1 = never).
  task automatic xfer(input logic [31:0] addr, input logic [1:0] sz,
                      input int cancel_at, input int err_at,
                      input int tmo_at, input int slow_at);
    int          nb;
    int          waits;
    bit          cancelled;
    bit          is_err;
    bit          is_tmo;
    bit          done;
    logic [3:0]  typ;
    logic [31:0] rd;
    logic [31:0] ea;
    logic [1:0]  eack;
    nb        = (sz == 2'b11) ? LINE_WDS : 1;
    cancelled = 1'b0;
    typ       = 4'($urandom);
    rd        = '0;
    bif.icu_req      = 1'b1;
    bif.icu_biu_addr = addr;
    bif.icu_type     = typ;
    bif.icu_size     = sz;
    @(negedge clk);
    for (int n = 0; n < nb; n++) begin
      is_err = (n == err_at);
      is_tmo = (n == tmo_at);
      done   = 1'b0;
      waits  = (n == slow_at) ? TMO : $urandom_range(0, 3);
      if (n == cancel_at && waits == 0) waits = 1;
      ea = exp_addr(addr, sz, n);
      for (int w = 0; !done; w++) begin
        chk("mem_req_hi", 32'(bif.mem_req), 32'd1);
        chk("mem_addr", bif.mem_addr, ea);
        chk("ack_quiet", 32'(bif.biu_icu_ack), 32'd0);
        if (w == 0) begin
          chk("mem_type", 32'(bif.mem_type), 32'(typ));
          chk("mem_size", 32'(bif.mem_size), (sz == 2'b11) ? 32'd2 : 32'(sz));
        end
        // Stray requests during a transfer must have no effect.
        bif.icu_req      = 1'($urandom_range(0, 1));
        bif.icu_biu_addr = $urandom;
        bif.icu_cancel   = (n == cancel_at && w == 0);
        if (n == cancel_at && w == 0) cancelled = 1'b1;
        if (!is_tmo && w == waits) begin
          rd            = $urandom;
          bif.mem_ack   = 1'b1;
          bif.mem_err   = is_err;
          bif.mem_rdata = rd;
          done          = 1'b1;
        end else if (is_tmo && w == TMO) begin
          done = 1'b1;
        end
        @(negedge clk);
        bif.mem_ack    = 1'b0;
        bif.mem_err    = 1'b0;
        bif.icu_cancel = 1'b0;
        bif.icu_req    = 1'b0;
      end
      eack = cancelled ? 2'b00 : (is_err || is_tmo) ? 2'b10 : (n == nb - 1) ? 2'b11 : 2'b01;
      chk("biu_ack", 32'(bif.biu_icu_ack), 32'(eack));
      if (!is_tmo) chk("biu_data", bif.biu_data, rd);
      chk("mem_req_lo", 32'(bif.mem_req), 32'd0);
      chk("busy_rsp", 32'(bif.biu_busy), 32'd1);
      if (is_err || is_tmo) break;
      if (n != nb - 1) @(negedge clk);
    end
    @(negedge clk);
    chk("busy_end", 32'(bif.biu_busy), 32'd0);
    chk("mem_req_end", 32'(bif.mem_req), 32'd0);
    chk("ack_end", 32'(bif.biu_icu_ack), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_mem_req"},  32'(bif.mem_req), 32'd0);
    chk({pfx, "_mem_addr"}, bif.mem_addr, 32'd0);
    chk({pfx, "_mem_type"}, 32'(bif.mem_type), 32'd0);
    chk({pfx, "_mem_size"}, 32'(bif.mem_size), 32'd0);
    chk({pfx, "_biu_data"}, bif.biu_data, 32'd0);
    chk({pfx, "_ack"},      32'(bif.biu_icu_ack), 32'd0);
    chk({pfx, "_busy"},     32'(bif.biu_busy), 32'd0);
  endtask

  logic [1:0] r_sz;
  int         r_nb, r_sel, r_ca, r_ea, r_ta, r_sa;

  initial begin
    reset            = 1'b1;
    bif.icu_req      = 1'b0;
    bif.icu_biu_addr = '0;
    bif.icu_type     = '0;
    bif.icu_size     = '0;
    bif.icu_cancel   = 1'b0;
    bif.mem_ack      = 1'b0;
    bif.mem_err      = 1'b0;
    bif.mem_rdata    = '0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");
    reset = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(bif.biu_busy), 32'd0);

    xfer(32'h0000_0100, 2'b10, -1, -1, -1, -1);  // single word
    xfer(32'h0000_2008, 2'b11, -1, -1, -1, -1);  // wrapping line fill
    xfer(32'h0000_200C, 2'b11, -1,  2, -1, -1);  // error on beat 2
    xfer(32'h0000_0200, 2'b10, -1, -1,  0, -1);  // word timeout
    xfer(32'h0000_3004, 2'b11, -1, -1,  1, -1);  // line timeout mid-fill
    xfer(32'h0000_4000, 2'b11,  1, -1, -1, -1);  // cancel during beat 1
    xfer(32'h0000_4104, 2'b10, -1, -1, -1, -1);  // serviced normally after cancel
    xfer(32'h0000_5004, 2'b11, -1, -1, -1,  3);  // ack on the last allowed cycle
    xfer(32'h0000_6003, 2'b00, -1, -1, -1, -1);  // byte, address unmodified
    xfer(32'h0000_6002, 2'b01,  0,  0, -1, -1);  // cancelled error stays silent

    // Reset mid-line, coinciding with a beat ack: nothing may be reported.
    bif.icu_req      = 1'b1;
    bif.icu_biu_addr = 32'h0000_7008;
    bif.icu_type     = 4'hA;
    bif.icu_size     = 2'b11;
    @(negedge clk);
    bif.icu_req = 1'b0;
    @(negedge clk);
    reset         = 1'b1;
    bif.mem_ack   = 1'b1;
    bif.mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    bif.mem_ack = 1'b0;
    chk_reset_outputs("midrst");
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_post_ack", 32'(bif.biu_icu_ack), 32'd0);
    chk("midrst_post_busy", 32'(bif.biu_busy), 32'd0);

    for (int t = 0; t < 24; t++) begin
      r_sz  = 2'($urandom_range(0, 3));
      r_nb  = (r_sz == 2'b11) ? LINE_WDS : 1;
      r_sel = $urandom_range(0, 9);
      r_ca  = -1;
      r_ea  = -1;
      r_ta  = -1;
      r_sa  = -1;
      case (r_sel)
        0: r_ca = $urandom_range(0, r_nb - 1);
        1: r_ea = $urandom_range(0, r_nb - 1);
        2: r_ta = $urandom_range(0, r_nb - 1);
        3: begin
          r_ca = $urandom_range(0, r_nb - 1);
          r_ea = $urandom_range(0, r_nb - 1);
        end
        default: ;
      endcase
      xfer($urandom, r_sz, r_ca, r_ea, r_ta, r_sa);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
